bsg_manycore_remote_req_arb: RTL and testbench

- Round-robin arbiter sharing one remote-request path (address/data/mask/op into the packet encoder and network) among num_req_p core-side requesters, e.g. LSU, icache refill and DMA.
- Holds one registered output request.
- Gates grants on an outstanding-request credit counter.
- Locks arbitration to one requester between its swap_aq and swap_rl, so atomic sequences are not interleaved.

---
 rtl/bsg_manycore_remote_req_arb_if.sv | 59 +++++
 rtl/bsg_manycore_remote_req_arb.sv | 195 +++++++++++++++++++
 tb/tb_bsg_manycore_remote_req_arb.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/bsg_manycore_remote_req_arb_if.sv
// Bundles the core-side requester bus and the encoder-side request bus
// of bsg_manycore_remote_req_arb. The arbiter uses the slave modport;
// the requester/encoder environment uses the master modport.
// With BSG_MANYCORE_REQ_ARB_STATS_EN defined, statistics outputs are added.
`timescale 1ns/1ps
interface bsg_manycore_remote_req_arb_if #(
  parameter int num_req_p         = 3,
  parameter int data_width_p      = 32,
  parameter int max_out_credits_p = 16
);
  localparam int credit_width_lp = $clog2(max_out_credits_p + 1);
  localparam int req_id_width_lp = (num_req_p > 1) ? $clog2(num_req_p) : 1;
  localparam int mask_width_lp   = data_width_p >> 3;

  // Requester side
  logic [num_req_p-1:0]               v_i;
  logic [num_req_p*32-1:0]            addr_i;
  logic [num_req_p*data_width_p-1:0]  data_i;
  logic [num_req_p*mask_width_lp-1:0] mask_i;
  logic [num_req_p*2-1:0]             op_i;
  logic [num_req_p-1:0]               yumi_o;

  // Encoder / network side
  logic                       enc_v_o;
  logic [31:0]                enc_addr_o;
  logic [data_width_p-1:0]    enc_data_o;
  logic [mask_width_lp-1:0]   enc_mask_o;
  logic                       enc_we_o;
  logic                       enc_swap_aq_o;
  logic                       enc_swap_rl_o;
  logic [req_id_width_lp-1:0] enc_req_id_o;
  logic                       enc_ready_i;
  logic                       credit_return_i;
  logic [credit_width_lp-1:0] out_credits_o;
  logic                       locked_o;

`ifdef BSG_MANYCORE_REQ_ARB_STATS_EN
  logic [num_req_p*32-1:0]    grant_count_o;
  logic [31:0]                credit_stall_count_o;
`endif

  modport slave (
    input  v_i, addr_i, data_i, mask_i, op_i, enc_ready_i, credit_return_i,
    output yumi_o, enc_v_o, enc_addr_o, enc_data_o, enc_mask_o, enc_we_o,
           enc_swap_aq_o, enc_swap_rl_o, enc_req_id_o, out_credits_o, locked_o
`ifdef BSG_MANYCORE_REQ_ARB_STATS_EN
  , output grant_count_o, credit_stall_count_o
`endif
  );

  modport master (
    output v_i, addr_i, data_i, mask_i, op_i, enc_ready_i, credit_return_i,
    input  yumi_o, enc_v_o, enc_addr_o, enc_data_o, enc_mask_o, enc_we_o,
           enc_swap_aq_o, enc_swap_rl_o, enc_req_id_o, out_credits_o, locked_o
`ifdef BSG_MANYCORE_REQ_ARB_STATS_EN
  , input grant_count_o, credit_stall_count_o
`endif
  );
endinterface

// File: rtl/bsg_manycore_remote_req_arb.sv
// Round-robin arbiter sharing one registered remote-request slot among
// num_req_p requesters. Grants are gated by an outstanding-request credit
// counter, and a swap_aq..swap_rl sequence locks arbitration to its owner.
// Optional statistics counters: define BSG_MANYCORE_REQ_ARB_STATS_EN.
`timescale 1ns/1ps
module bsg_manycore_remote_req_arb #(
  parameter int num_req_p         = 3,
  parameter int data_width_p      = 32,
  parameter int max_out_credits_p = 16
) (
  input logic                          clk_i,
  input logic                          reset_n_i,
  bsg_manycore_remote_req_arb_if.slave bus_if
);
  localparam int credit_width_lp = $clog2(max_out_credits_p + 1);
  localparam int req_id_width_lp = (num_req_p > 1) ? $clog2(num_req_p) : 1;
  localparam int mask_width_lp   = data_width_p >> 3;
  localparam logic [credit_width_lp-1:0] max_credits_lp = credit_width_lp'(max_out_credits_p);

  typedef enum logic [1:0] {
    e_op_load    = 2'd0,
    e_op_store   = 2'd1,
    e_op_swap_aq = 2'd2,
    e_op_swap_rl = 2'd3
  } op_e;

  typedef enum logic {e_idle = 1'b0, e_locked = 1'b1} lock_state_e;

  lock_state_e                state_q, state_d;
  logic [req_id_width_lp-1:0] owner_q, owner_d;
  logic [req_id_width_lp-1:0] rr_ptr_q, rr_ptr_d;
  logic [credit_width_lp-1:0] credits_q, credits_d;

  logic                       enc_v_q;
  logic [31:0]                enc_addr_q;
  logic [data_width_p-1:0]    enc_data_q;
  logic [mask_width_lp-1:0]   enc_mask_q;
  logic                       enc_we_q, enc_aq_q, enc_rl_q;
  logic [req_id_width_lp-1:0] enc_id_q;

  logic [num_req_p-1:0]       eligible;
  logic [num_req_p-1:0]       yumi;
  logic [req_id_width_lp-1:0] grant_id;
  logic                       found, slot_free, credit_avail, grant_v;
  op_e                        grant_op;

  assign slot_free    = ~enc_v_q | bus_if.enc_ready_i;
  assign credit_avail = (credits_q != '0) | bus_if.credit_return_i;
  assign grant_v      = slot_free & credit_avail & found & reset_n_i;
  assign grant_op     = op_e'(bus_if.op_i[int'(grant_id)*2 +: 2]);

  // Eligibility: everyone when idle, only the lock owner when locked.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    eligible = bus_if.v_i;
    if (state_q == e_locked) eligible = bus_if.v_i & (num_req_p'(1) << owner_q);
  end

  // Round-robin search: first eligible requester at or above rr_ptr_q, with wrap.
  always_comb begin
    int                         idx;
    logic [req_id_width_lp-1:0] idx_w;
    found    = 1'b0;
    grant_id = '0;
    for (int i = 0; i < num_req_p; i++) begin
      idx = int'(rr_ptr_q) + i;
      if (idx >= num_req_p) idx = idx - num_req_p;
      idx_w = req_id_width_lp'(idx);
      if (!found && eligible[idx_w]) begin
        found    = 1'b1;
        grant_id = idx_w;
      end
    end
  end

  // One-hot accept and next round-robin pointer.
  always_comb begin
    yumi     = '0;
    rr_ptr_d = rr_ptr_q;
    if (grant_v) begin
      yumi[grant_id] = 1'b1;
      rr_ptr_d = (int'(grant_id) == num_req_p - 1) ? '0 : grant_id + 1'b1;
    end
  end

  // Credit accounting: grant consumes, return restores, both cancel out.
  always_comb begin
    credits_d = credits_q;
    case ({grant_v, bus_if.credit_return_i})
      2'b10:   credits_d = credits_q - 1'b1;
      2'b01:   if (credits_q != max_credits_lp) credits_d = credits_q + 1'b1;
      default: credits_d = credits_q;
    endcase
  end

  // Lock FSM next state: swap_aq locks to its requester, owner's swap_rl unlocks.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    if (grant_v) begin
      case (state_q)
        e_idle: if (grant_op == e_op_swap_aq) begin
          state_d = e_locked;
          owner_d = grant_id;
        end
        e_locked: if (grant_op == e_op_swap_rl) state_d = e_idle;
        default: state_d = e_idle;
      endcase
    end
  end

  // Control state registers.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!reset_n_i) begin
      state_q   <= e_idle;
      owner_q   <= '0;
      rr_ptr_q  <= '0;
      credits_q <= max_credits_lp;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      rr_ptr_q  <= rr_ptr_d;
      credits_q <= credits_d;
    end
  end

  // Output request slot: load on grant, clear on dequeue, otherwise hold.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      enc_v_q    <= 1'b0;
      enc_addr_q <= '0;
      enc_data_q <= '0;
      enc_mask_q <= '0;
      enc_we_q   <= 1'b0;
      enc_aq_q   <= 1'b0;
      enc_rl_q   <= 1'b0;
      enc_id_q   <= '0;
    end else if (grant_v) begin
      enc_v_q    <= 1'b1;
      enc_addr_q <= bus_if.addr_i[int'(grant_id)*32 +: 32];
      enc_data_q <= bus_if.data_i[int'(grant_id)*data_width_p +: data_width_p];
      enc_mask_q <= bus_if.mask_i[int'(grant_id)*mask_width_lp +: mask_width_lp];
      enc_we_q   <= (grant_op == e_op_store);
      enc_aq_q   <= (grant_op == e_op_swap_aq);
      enc_rl_q   <= (grant_op == e_op_swap_rl);
      enc_id_q   <= grant_id;
    end else if (slot_free) begin
      enc_v_q    <= 1'b0;
    end
  end

`ifndef SYNTHESIS
  // A credit returned while already at the maximum indicates an upstream bug.
  always_ff @(posedge clk_i) begin
    if (reset_n_i && bus_if.credit_return_i && !grant_v && credits_q == max_credits_lp)
      $error("credit return with credits already at maximum");
  end
`endif

`ifdef BSG_MANYCORE_REQ_ARB_STATS_EN
  logic [num_req_p*32-1:0] grant_count_q;
  logic [31:0]             stall_count_q;

  // Per-requester grant counts and credit-starved cycle count.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      grant_count_q <= '0;
      stall_count_q <= '0;
    end else begin
      if (grant_v)
        grant_count_q[int'(grant_id)*32 +: 32] <= grant_count_q[int'(grant_id)*32 +: 32] + 32'd1;
      if (found && slot_free && credits_q == '0 && !bus_if.credit_return_i)
        stall_count_q <= stall_count_q + 32'd1;
    end
  end

  assign bus_if.grant_count_o        = grant_count_q;
  assign bus_if.credit_stall_count_o = stall_count_q;
`else
  // Statistics counters are not built in this configuration.
`endif

  assign bus_if.yumi_o        = yumi;
  assign bus_if.enc_v_o       = enc_v_q;
  assign bus_if.enc_addr_o    = enc_addr_q;
  assign bus_if.enc_data_o    = enc_data_q;
  assign bus_if.enc_mask_o    = enc_mask_q;
  assign bus_if.enc_we_o      = enc_we_q;
  assign bus_if.enc_swap_aq_o = enc_aq_q;
  assign bus_if.enc_swap_rl_o = enc_rl_q;
  assign bus_if.enc_req_id_o  = enc_id_q;
  assign bus_if.out_credits_o = credits_q;
  assign bus_if.locked_o      = (state_q == e_locked);
endmodule

// File: tb/tb_bsg_manycore_remote_req_arb.sv
// Directed bench for bsg_manycore_remote_req_arb: round-robin order,
// back-pressure, credit exhaustion/return, swap locking and async reset.
// Granted requests are queued from the driven stimulus and compared when
// the encoder side dequeues them.
`timescale 1ns/1ps
module tb_bsg_manycore_remote_req_arb;
  localparam int n_lp  = 3;
  localparam int dw_lp = 32;
  localparam int mw_lp = dw_lp >> 3;

  localparam logic [1:0] op_load = 2'd0, op_store = 2'd1, op_aq = 2'd2, op_rl = 2'd3;

  typedef struct packed {
    logic [31:0]      addr;
    logic [dw_lp-1:0] data;
    logic [mw_lp-1:0] mask;
    logic             we;
    logic             aq;
    logic             rl;
    logic [1:0]       id;
  } pkt_t;

  logic clk;
  logic rst_n;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_fail   = 0;

  logic [31:0]      r_addr [n_lp];
  logic [dw_lp-1:0] r_data [n_lp];
  logic [mw_lp-1:0] r_mask [n_lp];
  logic [1:0]       r_op   [n_lp];
  pkt_t             sb[$];

  bsg_manycore_remote_req_arb_if #(
    .num_req_p(n_lp), .data_width_p(dw_lp), .max_out_credits_p(16)
  ) bus ();

  bsg_manycore_remote_req_arb #(
    .num_req_p(n_lp), .data_width_p(dw_lp), .max_out_credits_p(16)
  ) dut (
    .clk_i    (clk),
    .reset_n_i(rst_n),
    .bus_if   (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic v, input logic [31:0] a,
                         input logic [dw_lp-1:0] d, input logic [mw_lp-1:0] m,
                         input logic [1:0] op);
    r_addr[i] = a;
    r_data[i] = d;
    r_mask[i] = m;
    r_op[i]   = op;
    bus.v_i[i]                   = v;
    bus.addr_i[i*32 +: 32]       = a;
    bus.data_i[i*dw_lp +: dw_lp] = d;
    bus.mask_i[i*mw_lp +: mw_lp] = m;
    bus.op_i[i*2 +: 2]           = op;
  endtask

  function automatic pkt_t make_pkt(input int g);
    pkt_t p;
    p.addr = r_addr[g];
    p.data = r_data[g];
    p.mask = r_mask[g];
    p.we   = (r_op[g] == op_store);
    p.aq   = (r_op[g] == op_aq);
    p.rl   = (r_op[g] == op_rl);
    p.id   = 2'(g);
    return p;
  endfunction

  // One cycle: inputs are already driven after the falling edge. Check the
  // accept vector, score any dequeue, record expected grants, then advance.
  task automatic step(input string tag, input logic [n_lp-1:0] exp_yumi);
    pkt_t o, e;
    #1;
    check({tag, " yumi"}, 128'(bus.yumi_o), 128'(exp_yumi));
    if (bus.enc_v_o && bus.enc_ready_i) begin
      o.addr = bus.enc_addr_o;
      o.data = bus.enc_data_o;
      o.mask = bus.enc_mask_o;
      o.we   = bus.enc_we_o;
      o.aq   = bus.enc_swap_aq_o;
      o.rl   = bus.enc_swap_rl_o;
      o.id   = bus.enc_req_id_o;
      check({tag, " dequeue expected"}, 128'(sb.size() != 0), 128'(1));
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check({tag, " packet"}, 128'(o), 128'(e));
      end
    end
    for (int g = 0; g < n_lp; g++)
      if (exp_yumi[g]) sb.push_back(make_pkt(g));
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst_n               = 1'b0;
    bus.v_i             = '0;
    bus.addr_i          = '0;
    bus.data_i          = '0;
    bus.mask_i          = '0;
    bus.op_i            = '0;
    bus.enc_ready_i     = 1'b1;
    bus.credit_return_i = 1'b0;
    for (int i = 0; i < n_lp; i++) set_req(i, 1'b0, 32'h0, '0, '0, op_load);

    // Requests presented while in reset must not be accepted.
    @(negedge clk);
    for (int i = 0; i < n_lp; i++) set_req(i, 1'b1, 32'h0, '0, '0, op_load);
    #1;
    check("in_reset yumi", 128'(bus.yumi_o), 128'(0));
    check("in_reset enc_v", 128'(bus.enc_v_o), 128'(0));
    for (int i = 0; i < n_lp; i++) set_req(i, 1'b0, 32'h0, '0, '0, op_load);

    // Reset release with no requests.
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("idle enc_v", 128'(bus.enc_v_o), 128'(0));
    check("idle credits", 128'(bus.out_credits_o), 128'(16));
    check("idle yumi", 128'(bus.yumi_o), 128'(0));
    check("idle locked", 128'(bus.locked_o), 128'(0));
    @(negedge clk);

    // All three requesting: round-robin 0,1,2,0,1,2.
    for (int i = 0; i < n_lp; i++)
      set_req(i, 1'b1, 32'h1000_0000 + 32'(i*16), 32'hA000_0000 + 32'(i), 4'hF, op_load);
    for (int k = 0; k < 6; k++) step("rr", n_lp'(1) << (k % 3));
    #1;
    check("rr credits", 128'(bus.out_credits_o), 128'(10));
    for (int i = 0; i < n_lp; i++) set_req(i, 1'b0, r_addr[i], r_data[i], r_mask[i], op_load);
    step("rr drain", 3'b000);
    #1;
    check("rr drained enc_v", 128'(bus.enc_v_o), 128'(0));

    // Store from requester 1 held under back-pressure for 3 cycles.
    set_req(1, 1'b1, 32'h2000_0010, 32'hDEAD_BEEF, 4'hF, op_store);
    step("store grant", 3'b010);
    bus.enc_ready_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("stall enc_v", 128'(bus.enc_v_o), 128'(1));
      check("stall addr", 128'(bus.enc_addr_o), 128'(32'h2000_0010));
      check("stall data", 128'(bus.enc_data_o), 128'(32'hDEAD_BEEF));
      check("stall we", 128'(bus.enc_we_o), 128'(1));
      step("stall", 3'b000);
    end
    bus.enc_ready_i = 1'b1;
    set_req(1, 1'b0, 32'h2000_0010, 32'hDEAD_BEEF, 4'hF, op_store);
    step("store dequeue", 3'b000);
    #1;
    check("store credits", 128'(bus.out_credits_o), 128'(9));

    // Exhaust the remaining 9 credits from requester 0.
    set_req(0, 1'b1, 32'h3000_0000, 32'h0000_1111, 4'h3, op_load);
    for (int k = 0; k < 9; k++) step("drain credits", 3'b001);
    #1;
    check("credits empty", 128'(bus.out_credits_o), 128'(0));
    step("no credit", 3'b000);
    #1;
    check("no credit enc_v", 128'(bus.enc_v_o), 128'(0));
    bus.credit_return_i = 1'b1;
    step("return grant", 3'b001);
    #1;
    check("return grant credits", 128'(bus.out_credits_o), 128'(0));
    set_req(0, 1'b0, 32'h3000_0000, 32'h0000_1111, 4'h3, op_load);
    for (int k = 0; k < 10; k++) step("refill", 3'b000);
    bus.credit_return_i = 1'b0;
    #1;
    check("refill credits", 128'(bus.out_credits_o), 128'(10));

    // Swap lock by requester 2 starves requester 0 until swap_rl.
    set_req(0, 1'b1, 32'h3000_0004, 32'h0000_2222, 4'hF, op_load);
    set_req(2, 1'b1, 32'h4000_0000, 32'h5555_0000, 4'hF, op_aq);
    step("swap_aq grant", 3'b100);
    #1;
    check("locked after aq", 128'(bus.locked_o), 128'(1));
    set_req(2, 1'b0, 32'h4000_0000, 32'h5555_0000, 4'hF, op_aq);
    step("starve", 3'b000);
    step("starve2", 3'b000);
    set_req(2, 1'b1, 32'h4000_0004, 32'h0000_6666, 4'hF, op_store);
    step("owner store", 3'b100);
    set_req(2, 1'b1, 32'h4000_0000, 32'h0000_7777, 4'hF, op_rl);
    #1;
    check("locked before rl", 128'(bus.locked_o), 128'(1));
    step("swap_rl grant", 3'b100);
    #1;
    check("unlocked after rl", 128'(bus.locked_o), 128'(0));
    set_req(2, 1'b0, 32'h4000_0000, 32'h0000_7777, 4'hF, op_rl);
    step("req0 after unlock", 3'b001);

    // Asynchronous reset with a pending locked request and 5 credits.
    set_req(0, 1'b1, 32'h3000_0008, 32'h0000_8888, 4'hF, op_aq);
    step("req0 swap_aq", 3'b001);
    bus.enc_ready_i = 1'b0;
    set_req(0, 1'b0, 32'h3000_0008, 32'h0000_8888, 4'hF, op_aq);
    #1;
    check("pre-reset enc_v", 128'(bus.enc_v_o), 128'(1));
    check("pre-reset locked", 128'(bus.locked_o), 128'(1));
    check("pre-reset credits", 128'(bus.out_credits_o), 128'(5));
    #1;
    rst_n = 1'b0;
    #1;
    check("async reset enc_v", 128'(bus.enc_v_o), 128'(0));
    check("async reset locked", 128'(bus.locked_o), 128'(0));
    check("async reset credits", 128'(bus.out_credits_o), 128'(16));
    check("async reset yumi", 128'(bus.yumi_o), 128'(0));
    sb.delete();
    @(negedge clk);
    rst_n           = 1'b1;
    bus.enc_ready_i = 1'b1;
    #1;
    check("post-reset enc_v", 128'(bus.enc_v_o), 128'(0));
    check("post-reset credits", 128'(bus.out_credits_o), 128'(16));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
